audio_jack_ctrl: RTL and testbench

AXI4-Lite slave that takes the audio-jack register block from fixed four-register scratch storage to a parametrised control and status block. It provides:
- N user RW registers with byte strobes.
- A control register, a status register with W1C sticky flags, and a threshold register.
- A sample FIFO filled from the audio-capture side and drained by CPU reads of a DATA register.
- A level-threshold interrupt.

It sits between the processor AXI interconnect and the audio-jack capture path of the pitch-training datapath.

---
 rtl/audio_jack_ctrl_pkg.sv | 47 ++++
 rtl/sample_fifo.sv | 59 +++++
 rtl/audio_jack_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_audio_jack_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_jack_ctrl_pkg.sv
// Shared definitions for the audio-jack control/status block: register map,
// bit positions, handshake state encoding and small helper functions.
package audio_jack_ctrl_pkg;

    // Byte offsets of the fixed registers; user registers follow USER_BASE.
    localparam int unsigned OFS_CTRL      = 32'h00;
    localparam int unsigned OFS_STATUS    = 32'h04;
    localparam int unsigned OFS_THRESH    = 32'h08;
    localparam int unsigned OFS_DATA      = 32'h0C;
    localparam int unsigned OFS_USER_BASE = 32'h10;

    // CTRL bit positions
    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_FLUSH  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    // STATUS bit positions (level lives in [15:0])
    localparam int unsigned STAT_UNDERFLOW = 29;
    localparam int unsigned STAT_EMPTY     = 30;
    localparam int unsigned STAT_OVERFLOW  = 31;

    localparam int unsigned THRESH_W = 16;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_ACK  = 2'd1,
        HS_RESP = 2'd2
    } hs_state_e;

    // Width needed to hold a FIFO occupancy of 0..depth.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Merge new_val into old_val on the byte lanes enabled by strb.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock show-ahead sample FIFO; pointer MSB distinguishes full/empty.
// Ports: i_clk/i_rst_n (sync active-low), i_push/i_pop/i_flush controls,
// i_data in; o_full_c/o_empty_c/o_level_c/o_head_c combinational status.
module sample_fifo
    import audio_jack_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic                          i_flush,
    input  logic [WIDTH-1:0]              i_data,
    output logic                          o_full_c,
    output logic                          o_empty_c,
    output logic [level_width(DEPTH)-1:0] o_level_c,
    output logic [WIDTH-1:0]              o_head_c
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = level_width(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      w_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty_c = (r_wr_ptr == r_rd_ptr);
    assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level_c = LVL_W'(w_count);
    assign o_head_c  = r_mem[r_rd_ptr[AW-1:0]];

    // A pop frees the slot a same-cycle push needs when full.
    assign w_pop_ok  = i_pop & ~o_empty_c;
    assign w_push_ok = i_push & (~o_full_c | w_pop_ok);

    // Pointer update; flush overrides any concurrent push/pop.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array
    always_ff @(posedge i_clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/audio_jack_ctrl.sv
// AXI4-Lite control/status block for the audio-jack capture path.
// Ports: S_AXI_* AXI4-Lite slave (sync active-low S_AXI_ARESETN),
// sample_valid/sample_data capture input, irq level interrupt,
// user_regs flat copy of the user RW registers.
module audio_jack_ctrl
    import audio_jack_ctrl_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned N_USER_REGS        = 4,
    parameter int unsigned SAMPLE_WIDTH       = 24,
    parameter int unsigned FIFO_DEPTH         = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [3:0]                      S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]         sample_data,
    output logic                            irq,
    output logic [N_USER_REGS*32-1:0]       user_regs
);

    localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int unsigned LVL_W = level_width(FIFO_DEPTH);

    hs_state_e r_wr_state, w_wr_next;
    hs_state_e r_rd_state, w_rd_next;
    logic      w_wr_en, w_rd_en;

    logic                          r_enable, r_irq_en, r_flush;
    logic [THRESH_W-1:0]           r_thresh;
    logic [31:0]                   r_user [N_USER_REGS];
    logic                          r_ovf, r_unf, r_irq;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, w_rdata_mux;

    logic [IDX_W-1:0]        w_wr_idx, w_rd_idx;
    logic                    w_fifo_full, w_fifo_empty;
    logic [LVL_W-1:0]        w_fifo_level;
    logic [SAMPLE_WIDTH-1:0] w_fifo_head;
    logic                    w_data_rd, w_pop, w_push_req;
    logic                    w_ovf_set, w_unf_set, w_ovf_clr, w_unf_clr, w_status_wr;
    logic                    w_unused;

    assign w_wr_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_rd_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Handshake state registers
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_wr_state <= HS_IDLE;
            r_rd_state <= HS_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
            r_rd_state <= w_rd_next;
        end
    end

    // Write/read handshake next-state; the accept strobe fires on leaving IDLE.
    always_comb begin
        w_wr_next = r_wr_state;
        w_rd_next = r_rd_state;
        w_wr_en   = 1'b0;
        w_rd_en   = 1'b0;
        case (r_wr_state)
            HS_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) begin
                w_wr_next = HS_ACK;
                w_wr_en   = 1'b1;
            end
            HS_ACK:  w_wr_next = HS_RESP;
            HS_RESP: if (S_AXI_BREADY) w_wr_next = HS_IDLE;
            default: w_wr_next = HS_IDLE;
        endcase
        case (r_rd_state)
            HS_IDLE: if (S_AXI_ARVALID) begin
                w_rd_next = HS_ACK;
                w_rd_en   = 1'b1;
            end
            HS_ACK:  w_rd_next = HS_RESP;
            HS_RESP: if (S_AXI_RREADY) w_rd_next = HS_IDLE;
            default: w_rd_next = HS_IDLE;
        endcase
    end

    assign S_AXI_AWREADY = (r_wr_state == HS_ACK);
    assign S_AXI_WREADY  = (r_wr_state == HS_ACK);
    assign S_AXI_BVALID  = (r_wr_state == HS_RESP);
    assign S_AXI_ARREADY = (r_rd_state == HS_ACK);
    assign S_AXI_RVALID  = (r_rd_state == HS_RESP);
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = r_rdata;
    assign irq           = r_irq;

    // FIFO control and sticky-flag events
    assign w_data_rd   = w_rd_en && (w_rd_idx == IDX_W'(OFS_DATA >> 2));
    assign w_pop       = w_data_rd & ~w_fifo_empty;
    assign w_unf_set   = w_data_rd & w_fifo_empty;
    assign w_push_req  = sample_valid & r_enable & ~r_flush;
    assign w_ovf_set   = w_push_req & w_fifo_full & ~w_pop;
    assign w_status_wr = w_wr_en && (w_wr_idx == IDX_W'(OFS_STATUS >> 2)) && S_AXI_WSTRB[3];
    assign w_ovf_clr   = w_status_wr & S_AXI_WDATA[STAT_OVERFLOW];
    assign w_unf_clr   = w_status_wr & S_AXI_WDATA[STAT_UNDERFLOW];

    sample_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (S_AXI_ACLK),
        .i_rst_n   (S_AXI_ARESETN),
        .i_push    (w_push_req),
        .i_pop     (w_pop),
        .i_flush   (r_flush),
        .i_data    (sample_data),
        .o_full_c  (w_fifo_full),
        .o_empty_c (w_fifo_empty),
        .o_level_c (w_fifo_level),
        .o_head_c  (w_fifo_head)
    );

    // Register file writes; FLUSH is a one-cycle pulse.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
            r_flush  <= 1'b0;
            r_thresh <= '0;
            for (int k = 0; k < N_USER_REGS; k++) r_user[k] <= '0;
        end else begin
            r_flush <= 1'b0;
            if (w_wr_en) begin
                if (w_wr_idx == IDX_W'(OFS_CTRL >> 2) && S_AXI_WSTRB[0]) begin
                    r_enable <= S_AXI_WDATA[CTRL_ENABLE];
                    r_irq_en <= S_AXI_WDATA[CTRL_IRQ_EN];
                    r_flush  <= S_AXI_WDATA[CTRL_FLUSH];
                end
                if (w_wr_idx == IDX_W'(OFS_THRESH >> 2)) begin
                    if (S_AXI_WSTRB[0]) r_thresh[7:0]  <= S_AXI_WDATA[7:0];
                    if (S_AXI_WSTRB[1]) r_thresh[15:8] <= S_AXI_WDATA[15:8];
                end
                for (int k = 0; k < N_USER_REGS; k++) begin
                    if (w_wr_idx == IDX_W'((OFS_USER_BASE >> 2) + k))
                        r_user[k] <= apply_strb(r_user[k], S_AXI_WDATA, S_AXI_WSTRB);
                end
            end
        end
    end

    // Sticky flags (set beats clear) and registered interrupt
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
            r_unf <= (r_unf & ~w_unf_clr) | w_unf_set;
            r_irq <= r_irq_en & (((THRESH_W'(w_fifo_level) >= r_thresh) && (r_thresh != '0)) | r_ovf);
        end
    end

    // Read data mux; unmapped addresses return zero.
    always_comb begin
        w_rdata_mux = '0;
        for (int k = 0; k < N_USER_REGS; k++) begin
            if (w_rd_idx == IDX_W'((OFS_USER_BASE >> 2) + k)) w_rdata_mux = r_user[k];
        end
        if (w_rd_idx == IDX_W'(OFS_CTRL >> 2)) begin
            w_rdata_mux[CTRL_ENABLE] = r_enable;
            w_rdata_mux[CTRL_IRQ_EN] = r_irq_en;
        end
        if (w_rd_idx == IDX_W'(OFS_STATUS >> 2)) begin
            w_rdata_mux[15:0]           = 16'(w_fifo_level);
            w_rdata_mux[STAT_UNDERFLOW] = r_unf;
            w_rdata_mux[STAT_EMPTY]     = w_fifo_empty;
            w_rdata_mux[STAT_OVERFLOW]  = r_ovf;
        end
        if (w_rd_idx == IDX_W'(OFS_THRESH >> 2)) w_rdata_mux[THRESH_W-1:0] = r_thresh;
        if (w_rd_idx == IDX_W'(OFS_DATA >> 2) && !w_fifo_empty)
            w_rdata_mux = C_S_AXI_DATA_WIDTH'(w_fifo_head);
    end

    // Read data is captured at acceptance and held through the response.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) r_rdata <= '0;
        else if (w_rd_en)   r_rdata <= w_rdata_mux;
    end

    for (genvar g = 0; g < N_USER_REGS; g++) begin : g_user_out
        assign user_regs[32*g +: 32] = r_user[g];
    end

endmodule

// File: tb/tb_audio_jack_ctrl.sv
// Self-checking bench for audio_jack_ctrl: transaction-level model plus an
// expected-value queue compared against each AXI read response.
module tb_audio_jack_ctrl;

    localparam int unsigned AW    = 6;
    localparam int unsigned NU    = 4;
    localparam int unsigned SW    = 24;
    localparam int unsigned DEPTH = 16;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [31:0]     wdata, rdata;
    logic [3:0]      wstrb;
    logic [1:0]      bresp, rresp;
    logic            sample_valid;
    logic [SW-1:0]   sample_data;
    logic            irq;
    logic [NU*32-1:0] user_regs;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    string       name_q [$];
    logic [SW-1:0] m_fifo [$];
    bit m_ovf, m_unf, m_enable;

    audio_jack_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .N_USER_REGS        (NU),
        .SAMPLE_WIDTH       (SW),
        .FIFO_DEPTH         (DEPTH)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .irq           (irq),
        .user_regs     (user_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input string nm, input int which);
        int n = 0;
        logic s;
        s = (which == 0) ? awready : (which == 1) ? bvalid : (which == 2) ? arready : rvalid;
        while (!s && n < 20) begin
            tick();
            n++;
            s = (which == 0) ? awready : (which == 1) ? bvalid : (which == 2) ? arready : rvalid;
        end
        if (!s) begin
            checks++;
            errors++;
            $display("FAIL %s: handshake timeout, got 0 required 1", nm);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        wait_sig("wr_accept", 0);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_sig("wr_resp", 1);
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
        araddr = a; arvalid = 1'b1;
        tick();
        wait_sig("rd_accept", 2);
        tick();
        arvalid = 1'b0; rready = 1'b1;
        wait_sig("rd_resp", 3);
        d = rdata;
        tick();
        rready = 1'b0;
    endtask

    // Expected value is queued with the request and compared when data returns.
    task automatic read_check(input logic [AW-1:0] a, input logic [31:0] e, input string nm);
        logic [31:0] d, exp_v;
        string en;
        exp_q.push_back(e);
        name_q.push_back(nm);
        axi_read(a, d);
        exp_v = exp_q.pop_front();
        en = name_q.pop_front();
        checks++;
        if (d !== exp_v) begin
            errors++;
            $display("FAIL %s: addr=0x%0h got 0x%08h required 0x%08h", en, a, d, exp_v);
        end
    endtask

    task automatic read_data_check(input string nm);
        logic [31:0] e;
        if (m_fifo.size() > 0) e = 32'(m_fifo.pop_front());
        else begin
            e = 32'h0;
            m_unf = 1'b1;
        end
        read_check(6'h0C, e, nm);
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s = 32'h0;
        s[15:0] = 16'(m_fifo.size());
        s[29]   = m_unf;
        s[30]   = (m_fifo.size() == 0);
        s[31]   = m_ovf;
        return s;
    endfunction

    task automatic write_ctrl(input logic [31:0] v);
        axi_write(6'h00, v, 4'hF);
        m_enable = v[0];
    endtask

    task automatic w1c(input logic [31:0] v);
        axi_write(6'h04, v, 4'b1000);
        if (v[31]) m_ovf = 1'b0;
        if (v[29]) m_unf = 1'b0;
    endtask

    task automatic push_sample(input logic [SW-1:0] v);
        sample_valid = 1'b1; sample_data = v;
        tick();
        sample_valid = 1'b0;
        if (m_enable) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(v);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", nm, got, req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        check_bit("rst_handshake", awready | wready | bvalid | arready | rvalid, 1'b0);
        check_bit("rst_irq", irq, 1'b0);
        checks++;
        if (rdata !== 32'h0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            errors++;
            $display("FAIL rst_data: rdata=0x%08h bresp=%b rresp=%b required 0", rdata, bresp, rresp);
        end
        rst_n = 1'b1;
        tick();
        read_check(6'h00, 32'h0, "rst_ctrl");
        read_check(6'h04, 32'h4000_0000, "rst_status");
        read_check(6'h08, 32'h0, "rst_thresh");
        for (int k = 0; k < NU; k++) read_check(AW'(6'h10 + 4 * k), 32'h0, "rst_user");
        read_check(6'h3C, 32'h0, "rst_unmapped");
        read_data_check("rst_data_empty");
        read_check(6'h04, 32'h2000_0000 | exp_status(), "rst_unf_set");
        w1c(32'h2000_0000);
        read_check(6'h04, 32'h4000_0000, "rst_unf_clr");
    endtask

    task automatic test_user_strobe();
        axi_write(6'h10, 32'hAABB_CCDD, 4'b0101);
        read_check(6'h10, 32'h00BB_00DD, "user0_strb");
        for (int k = 1; k < NU; k++) read_check(AW'(6'h10 + 4 * k), 32'h0, "user_other");
        checks++;
        if (user_regs !== {96'h0, 32'h00BB_00DD}) begin
            errors++;
            $display("FAIL user_regs_out: got 0x%032h required 0x%08h in low word", user_regs, 32'h00BB_00DD);
        end
        axi_write(6'h24, 32'hDEAD_BEEF, 4'hF);
        read_check(6'h24, 32'h0, "unmapped_wr");
    endtask

    task automatic test_fifo_order();
        write_ctrl(32'h1);
        push_sample(24'h123456);
        push_sample(24'h000001);
        push_sample(24'hFFFFFF);
        read_check(6'h04, 32'h0000_0003, "fifo_level3");
        for (int i = 0; i < 3; i++) read_data_check("fifo_order");
        read_data_check("fifo_underflow_data");
        read_check(6'h04, 32'h6000_0000, "fifo_underflow_flag");
        w1c(32'h2000_0000);
        read_check(6'h04, exp_status(), "fifo_unf_clear");
    endtask

    task automatic test_irq_thresh();
        axi_write(6'h08, 32'hFFFF_0004, 4'b0011);
        read_check(6'h08, 32'h0000_0004, "thresh_strb");
        write_ctrl(32'h5);
        for (int i = 0; i < 3; i++) push_sample(SW'(24'h000A00 + i));
        tick();
        tick();
        check_bit("irq_below_thresh", irq, 1'b0);
        push_sample(24'h000A03);
        check_bit("irq_latency", irq, 1'b0);
        tick();
        check_bit("irq_at_thresh", irq, 1'b1);
        read_data_check("irq_pop_data");
        check_bit("irq_drop", irq, 1'b0);
        for (int i = 0; i < 3; i++) read_data_check("irq_drain");
        read_check(6'h04, exp_status(), "irq_status_empty");
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        axi_write(6'h08, 32'h0, 4'hF);
        for (int i = 0; i < DEPTH + 2; i++) push_sample(SW'(24'h000100 + i));
        read_check(6'h04, 32'h8000_0010, "ovf_status");
        check_bit("ovf_irq", irq, 1'b1);
        w1c(32'h8000_0000);
        check_bit("ovf_irq_clear", irq, 1'b0);
        read_check(6'h04, 32'h0000_0010, "ovf_cleared");
        // DATA read accepted on the same edge as a push into the full FIFO
        araddr = 6'h0C; arvalid = 1'b1; sample_valid = 1'b1; sample_data = 24'h0ABCDE;
        e = 32'(m_fifo.pop_front());
        m_fifo.push_back(24'h0ABCDE);
        exp_q.push_back(e);
        tick();
        sample_valid = 1'b0;
        check_bit("full_pop_push_accept", arready, 1'b1);
        tick();
        arvalid = 1'b0; rready = 1'b1;
        wait_sig("full_pop_push_resp", 3);
        d = rdata;
        tick();
        rready = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL full_pop_push_data: got 0x%08h required 0x%08h", d, e);
        end
        read_check(6'h04, 32'h0000_0010, "full_pop_push_no_ovf");
        for (int i = 0; i < DEPTH; i++) read_data_check("ovf_drain");
        read_check(6'h04, exp_status(), "ovf_drained");
    endtask

    task automatic test_flush();
        write_ctrl(32'h1);
        push_sample(24'h000011);
        push_sample(24'h000022);
        awaddr = 6'h00; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        sample_valid = 1'b1; sample_data = 24'h000777;
        tick();
        sample_valid = 1'b0;
        check_bit("flush_accept", awready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_sig("flush_resp", 1);
        tick();
        bready = 1'b0;
        m_fifo.delete();
        read_check(6'h04, 32'h4000_0000, "flush_empty");
        read_check(6'h00, 32'h0000_0001, "flush_selfclear");
        read_data_check("flush_no_data");
        w1c(32'h2000_0000);
    endtask

    task automatic test_back_to_back();
        bit hold_ok = 1'b1;
        bit block_ok = 1'b1;
        bready = 1'b0;
        awaddr = 6'h14; wdata = 32'h1111_1111; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        wait_sig("b2b_first_accept", 0);
        tick();
        awaddr = 6'h18; wdata = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            if (bvalid !== 1'b1) hold_ok = 1'b0;
            if (awready !== 1'b0 || wready !== 1'b0) block_ok = 1'b0;
            tick();
        end
        check_bit("b2b_bvalid_hold", hold_ok, 1'b1);
        check_bit("b2b_second_blocked", block_ok, 1'b1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        wait_sig("b2b_second_accept", 0);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_sig("b2b_second_resp", 1);
        tick();
        bready = 1'b0;
        read_check(6'h14, 32'h1111_1111, "b2b_user1");
        read_check(6'h18, 32'h2222_2222, "b2b_user2");
        read_check(6'h1C, 32'h0, "b2b_user3");
    endtask

    task automatic test_reset_midflight();
        write_ctrl(32'h1);
        push_sample(24'h000055);
        push_sample(24'h000066);
        araddr = 6'h04; arvalid = 1'b1;
        tick();
        wait_sig("mid_rd_accept", 2);
        rst_n = 1'b0;
        tick();
        check_bit("mid_rst_drop", arready | rvalid | awready | bvalid | irq, 1'b0);
        arvalid = 1'b0;
        rst_n = 1'b1;
        tick();
        m_fifo.delete();
        m_enable = 1'b0;
        read_check(6'h04, 32'h4000_0000, "mid_rst_fifo_clear");
        read_check(6'h00, 32'h0, "mid_rst_ctrl");
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0; sample_valid = 1'b0; sample_data = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_enable = 1'b0;
        test_reset();
        test_user_strobe();
        test_fifo_order();
        test_irq_thresh();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
